alu_arbiter: RTL and testbench

Shares the single combinational ALU in the execute stage between two requesters. Requester 0 is the main pipeline issue slot; requester 1 is an auxiliary unit, such as address generation or a future multi-cycle M-extension sequencer. The block:
- arbitrates round-robin between the two requesters;
- drives the ALU operands and opcode from the winner;
- registers the ALU result into a one-entry response buffer with valid/ready handshake and requester ID.

---
 rtl/alu_arbiter.sv | 120 ++++++++++++
 tb/tb_alu_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing the execute-stage ALU between two requesters.
// Optional opcode check enabled by defining ALU_ARB_ILLEGAL_CHK_EN.
module alu_arbiter #(
   parameter int DW  = 32,
   parameter int OPW = 4
) (
   input  logic           i_clk,
   input  logic           i_reset,
   input  logic           i_req0_valid,
   input  logic [DW-1:0]  i_req0_op_a,
   input  logic [DW-1:0]  i_req0_op_b,
   input  logic [OPW-1:0] i_req0_alu_op,
   output logic           o_req0_ready,
   input  logic           i_req1_valid,
   input  logic [DW-1:0]  i_req1_op_a,
   input  logic [DW-1:0]  i_req1_op_b,
   input  logic [OPW-1:0] i_req1_alu_op,
   output logic           o_req1_ready,
   output logic [DW-1:0]  o_alu_op_a,
   output logic [DW-1:0]  o_alu_op_b,
   output logic [OPW-1:0] o_alu_op,
   input  logic [DW-1:0]  i_alu_data,
   output logic           o_rsp_valid,
   output logic           o_rsp_id,
   output logic [DW-1:0]  o_rsp_data,
   output logic           o_rsp_err,
   input  logic           i_rsp_ready
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t        state;
   logic          last_grant;
   logic          win;
   logic          has_win;
   logic          can_accept;
   logic          accept;
   logic          acc_err;
   logic [DW-1:0] acc_data;
   logic          rsp_id_q;
   logic [DW-1:0] rsp_data_q;
   logic          rsp_err_q;

   // Tie goes to whichever requester was not granted last.
   always_comb begin
      win     = 1'b0;
      has_win = i_req0_valid | i_req1_valid;
      unique case (1'b1)
         (i_req0_valid & i_req1_valid):  win = ~last_grant;
         (~i_req0_valid & i_req1_valid): win = 1'b1;
         default:                        win = 1'b0;
      endcase
   end

   assign can_accept   = (state == EMPTY) | i_rsp_ready;
   assign o_req0_ready = i_reset & can_accept & i_req0_valid & ~win;
   assign o_req1_ready = i_reset & can_accept & i_req1_valid & win;
   assign accept       = o_req0_ready | o_req1_ready;

   always_comb begin
      o_alu_op_a = '0;
      o_alu_op_b = '0;
      o_alu_op   = '0;
      if (has_win) begin
         if (win) begin
            o_alu_op_a = i_req1_op_a;
            o_alu_op_b = i_req1_op_b;
            o_alu_op   = i_req1_alu_op;
         end else begin
            o_alu_op_a = i_req0_op_a;
            o_alu_op_b = i_req0_op_b;
            o_alu_op   = i_req0_alu_op;
         end
      end
   end

`ifdef ALU_ARB_ILLEGAL_CHK_EN
   function automatic logic op_legal(input logic [OPW-1:0] op);
      case (op)
         OPW'(0), OPW'(1), OPW'(2), OPW'(3),
         OPW'(4), OPW'(5), OPW'(6),
         OPW'(8), OPW'(9), OPW'(10): op_legal = 1'b1;
         default:                    op_legal = 1'b0;
      endcase
   endfunction

   assign acc_err  = ~op_legal(o_alu_op);
   assign acc_data = acc_err ? '0 : i_alu_data;
`else
   assign acc_err  = 1'b0;
   assign acc_data = i_alu_data;
`endif

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         state      <= EMPTY;
         last_grant <= 1'b1;
         rsp_id_q   <= 1'b0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
      end else if (accept) begin
         state      <= FULL;
         last_grant <= o_req1_ready;
         rsp_id_q   <= o_req1_ready;
         rsp_data_q <= acc_data;
         rsp_err_q  <= acc_err;
      end else if (state == FULL && i_rsp_ready) begin
         state <= EMPTY;
      end
   end

   assign o_rsp_valid = (state == FULL);
   assign o_rsp_id    = rsp_id_q;
   assign o_rsp_data  = rsp_data_q;
   assign o_rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU on the operand bus.
// Expected values are hand-computed constants.
module tb_alu_arbiter;

   localparam int DW  = 32;
   localparam int OPW = 4;

   logic           clk;
   logic           rst_n;
   logic           v0, v1;
   logic [DW-1:0]  a0, b0, a1, b1;
   logic [OPW-1:0] op0, op1;
   logic           rdy0, rdy1;
   logic [DW-1:0]  alu_a, alu_b, alu_y;
   logic [OPW-1:0] alu_op;
   logic           rsp_valid, rsp_id, rsp_err, rsp_ready;
   logic [DW-1:0]  rsp_data;

   int nvec = 0;
   int nerr = 0;

   alu_arbiter #(.DW(DW), .OPW(OPW)) dut (
      .i_clk         (clk),
      .i_reset       (rst_n),
      .i_req0_valid  (v0),
      .i_req0_op_a   (a0),
      .i_req0_op_b   (b0),
      .i_req0_alu_op (op0),
      .o_req0_ready  (rdy0),
      .i_req1_valid  (v1),
      .i_req1_op_a   (a1),
      .i_req1_op_b   (b1),
      .i_req1_alu_op (op1),
      .o_req1_ready  (rdy1),
      .o_alu_op_a    (alu_a),
      .o_alu_op_b    (alu_b),
      .o_alu_op      (alu_op),
      .i_alu_data    (alu_y),
      .o_rsp_valid   (rsp_valid),
      .o_rsp_id      (rsp_id),
      .o_rsp_data    (rsp_data),
      .o_rsp_err     (rsp_err),
      .i_rsp_ready   (rsp_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference ALU; unknown opcodes produce a recognisable pattern.
   always_comb begin
      alu_y = 32'hDEAD_BEEF;
      case (alu_op)
         4'b0000: alu_y = alu_a + alu_b;
         4'b0001: alu_y = alu_a - alu_b;
         4'b0010: alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
         4'b0011: alu_y = {31'd0, alu_a < alu_b};
         4'b0100: alu_y = alu_a >> alu_b[4:0];
         4'b0101: alu_y = alu_a << alu_b[4:0];
         4'b0110: alu_y = $signed(alu_a) >>> alu_b[4:0];
         4'b1000: alu_y = alu_a ^ alu_b;
         4'b1001: alu_y = alu_a | alu_b;
         4'b1010: alu_y = alu_a & alu_b;
         default: alu_y = 32'hDEAD_BEEF;
      endcase
   end

   task automatic check(input string tag, input logic [DW-1:0] got,
                        input logic [DW-1:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic rsp(input string tag, input logic v, input logic id,
                      input logic [DW-1:0] d, input logic e);
      check({tag, "_valid"}, DW'(rsp_valid), DW'(v));
      check({tag, "_id"},    DW'(rsp_id),    DW'(id));
      check({tag, "_data"},  rsp_data,       d);
      check({tag, "_err"},   DW'(rsp_err),   DW'(e));
   endtask

   task automatic rdy(input string tag, input logic r0, input logic r1);
      check({tag, "_rdy0"}, DW'(rdy0), DW'(r0));
      check({tag, "_rdy1"}, DW'(rdy1), DW'(r1));
   endtask

   initial begin
      rst_n = 1'b0; rsp_ready = 1'b1;
      v0 = 1'b1; a0 = 32'd1; b0 = 32'd2; op0 = 4'b0000;
      v1 = 1'b1; a1 = 32'd3; b1 = 32'd4; op1 = 4'b0000;

      // Reset held two cycles with both requesters valid
      for (int i = 0; i < 2; i++) begin
         settle();
         rdy("rst", 1'b0, 1'b0);
         tick();
         rsp("rst", 1'b0, 1'b0, 32'd0, 1'b0);
      end

      // Idle: ALU bus driven to ADD 0+0
      rst_n = 1'b1; v0 = 1'b0; v1 = 1'b0;
      settle();
      check("idle_alu_a", alu_a, 32'd0);
      check("idle_alu_op", DW'(alu_op), 32'd0);
      rdy("idle", 1'b0, 1'b0);

      // Single request
      v0 = 1'b1; a0 = 32'd3232453; b0 = 32'd4995; op0 = 4'b0000;
      settle();
      rdy("single", 1'b1, 1'b0);
      check("single_alu_a", alu_a, 32'd3232453);
      tick();
      rsp("single", 1'b1, 1'b0, 32'd3237448, 1'b0);

      // Lone req1 so the next tie starts at req0
      v0 = 1'b0;
      v1 = 1'b1; a1 = 32'h0000_F0F0; b1 = 32'h0000_0FF0; op1 = 4'b1000;
      settle();
      rdy("lone1", 1'b0, 1'b1);
      tick();
      rsp("lone1", 1'b1, 1'b1, 32'h0000_FF00, 1'b0);

      // Contention: grants 0,1,0,1
      v0 = 1'b1; a0 = 32'd343735889; b0 = 32'(-392837334); op0 = 4'b0001;
      v1 = 1'b1; a1 = 32'd449;       b1 = 32'd12;           op1 = 4'b0101;
      for (int i = 0; i < 2; i++) begin
         settle();
         rdy("tie_g0", 1'b1, 1'b0);
         tick();
         rsp("tie_r0", 1'b1, 1'b0, 32'd736573223, 1'b0);
         rdy("tie_g1", 1'b0, 1'b1);
         tick();
         rsp("tie_r1", 1'b1, 1'b1, 32'd1839104, 1'b0);
      end

      // Backpressure
      v1 = 1'b0; a0 = 32'd1; b0 = 32'd2; op0 = 4'b0000;
      settle();
      rdy("bp_acc", 1'b1, 1'b0);
      tick();
      v0 = 1'b0; rsp_ready = 1'b0;
      v1 = 1'b1; a1 = 32'h0000_00FF; b1 = 32'h0000_000F; op1 = 4'b1010;
      for (int i = 0; i < 3; i++) begin
         settle();
         rdy("bp_hold", 1'b0, 1'b0);
         rsp("bp_hold", 1'b1, 1'b0, 32'd3, 1'b0);
         tick();
      end
      rsp_ready = 1'b1;
      settle();
      rdy("bp_rel", 1'b0, 1'b1);
      tick();
      rsp("bp_rel", 1'b1, 1'b1, 32'h0000_000F, 1'b0);
      v1 = 1'b0;
      tick();
      rsp("bp_pop", 1'b0, 1'b1, 32'h0000_000F, 1'b0);

      // Illegal opcode from req1
      v1 = 1'b1; a1 = 32'd5; b1 = 32'd3; op1 = 4'b0111;
      settle();
      rdy("ill", 1'b0, 1'b1);
      tick();
`ifdef ALU_ARB_ILLEGAL_CHK_EN
      rsp("ill", 1'b1, 1'b1, 32'd0, 1'b1);
`else
      rsp("ill", 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0);
`endif

      // Reset while FULL discards the result
      v1 = 1'b0; rsp_ready = 1'b0;
      tick();
      check("pre_rst_valid", DW'(rsp_valid), 32'd1);
      rst_n = 1'b0; rsp_ready = 1'b1;
      v0 = 1'b1; a0 = 32'd10; b0 = 32'd4; op0 = 4'b0001;
      v1 = 1'b1; a1 = 32'd7;  b1 = 32'd1; op1 = 4'b0101;
      settle();
      rdy("mid_rst", 1'b0, 1'b0);
      tick();
      rsp("mid_rst", 1'b0, 1'b0, 32'd0, 1'b0);
      rst_n = 1'b1;
      settle();
      rdy("post_rst", 1'b1, 1'b0);
      check("post_rst_alu_op", DW'(alu_op), 32'd1);
      tick();
      rsp("post_rst", 1'b1, 1'b0, 32'd6, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
